branch_result_unit: RTL
=======================

# branch_result_unit

Tracks every branch the fetch stage predicted, from allocation until commit. When an execute lane resolves a branch, the block compares the outcome with the stored prediction and emits a registered branch-result record: address, global history, previous counter value, taken flag and mispredict flag. This is the producer side of the branch-result interface that the branch predictor consumes to train its counters and repair its global history. It sits between the fetch stage (writer of prediction records) and the integer execute pipes (readers by tag).

## Interface
- FETCH_WIDTH, default 2: maximum prediction records allocated per cycle.
- INT_ISSUE_WIDTH, default 2: resolve lanes, and also the maximum commits per cycle.
- QUEUE_SIZE, default 16: record entries; must be a power of two. TAG_W = log2(QUEUE_SIZE).
- ADDR_WIDTH, default 32; GH_WIDTH, default 10; PHT_ENTRY_WIDTH, default 2.
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- alloc_valid  in  FETCH_WIDTH  per-slot request; slots are in program order.
- alloc_addr / alloc_gh / alloc_pht / alloc_taken / alloc_target  in  per slot ADDR_WIDTH / GH_WIDTH / PHT_ENTRY_WIDTH / 1 / ADDR_WIDTH  prediction record.
- alloc_ready  out  1  all requested slots fit this cycle.
- alloc_tag  out  FETCH_WIDTH x TAG_W  tag given to each valid slot, combinational.
- res_valid, res_tag, res_taken, res_target, res_is_cond  in  per lane 1 / TAG_W / 1 / ADDR_WIDTH / 1  resolved outcome.
- br_valid, br_addr, br_gh, br_pht_prev, br_exec_taken, br_is_cond, br_mispred  out  per lane  registered branch-result record.
- commit_num  in  log2(INT_ISSUE_WIDTH)+1  number of records retired from the head this cycle.
- count  out  TAG_W+1  occupied entries.

## Operation
- Storage is a circular buffer addressed by head and tail pointers, each TAG_W+1 bits. The top bit is the wrap bit.
  - empty when head == tail.
  - count = tail − head, modulo 2^(TAG_W+1).
- Allocation:
  - n = popcount(alloc_valid); alloc_ready = (QUEUE_SIZE − count ≥ n).
  - When alloc_ready and n > 0, the k-th valid slot, in slot order, is written at index (tail + k) mod QUEUE_SIZE, and alloc_tag returns that index. tail += n.
  - If alloc_ready is low, nothing is written. There is no partial allocation.
- Resolve, per lane with res_valid:
  - Read the entry at res_tag.
  - Conditional branch: mispred = (res_taken ≠ stored taken) or (res_taken and res_target ≠ stored target).
  - Non-conditional branch: mispred = (!stored taken) or (res_target ≠ stored target).
  - Register the stored addr, gh and pht together with res_taken, res_is_cond and mispred onto the br_* outputs.
- Recovery:
  - If any lane mispredicts, pick the oldest such lane, where age = (res_tag − head) mod QUEUE_SIZE.
  - Set tail to the pointer of that entry + 1. All younger records are squashed.
  - Allocation in that cycle is dropped regardless of alloc_ready.
- Commit: head += min(commit_num, count). A commit_num above count is clipped, and a simulation assertion fires.
- Simultaneous commit and recovery: both apply. If the new tail would fall behind the new head, tail = head.
- Resolve of a tag outside [head, tail) is ignored: br_valid stays 0 and an assertion fires.

## Timing
- alloc_ready and alloc_tag are combinational from count and alloc_valid. Entries become readable one cycle after allocation.
- Resolve-to-br_* latency is exactly 1 cycle. br_valid is a 1-cycle pulse per resolved lane.
- Pointer updates from allocate, recover and commit take effect at the next posedge.
- Reset (rst_n low, asynchronous):
  - head = tail = 0, count = 0, alloc_ready = 1.
  - All br_* outputs = 0.
  - Entry contents are undefined.
  - Reset asserted mid-operation discards all in-flight records and any pending br_* pulse immediately.
- Full boundary: with count = QUEUE_SIZE − 1, a single-slot request is accepted and a two-slot request is refused.

## Test plan
- Reset, then allocate 2 slots (addr 0x100, 0x104) -> tags 0 and 1, count = 2. Resolve tag 1 with a matching outcome -> one cycle later br_valid = 1, br_addr = 0x104, br_mispred = 0.
- Fill 15 entries, then request 2 slots -> alloc_ready = 0 and count stays 15. Request 1 slot -> accepted, count = 16.
- Allocate tags 0–5. Resolve tag 2 with taken = 1 where predicted = 0 -> br_mispred = 1 and tail = 3. An allocation in the same cycle is dropped, and the next allocation returns tag 3.
- Two lanes both mispredict (tags 4 and 2, head = 1) -> recovery uses tag 2, so tail = 3, and both br_* records are emitted.
- Wrap-around: commit and allocate continuously for 40 cycles -> tags cycle through 0–15, count is never above 16, and records stay bit-exact after wrap.
- Assert rst_n low while count = 7 and a resolve is in flight -> br_valid = 0 and count = 0 immediately. After release, the first allocation gets tag 0.

Source files
------------

// File: rtl/branch_result_unit.sv
// Branch result unit: holds fetch-stage prediction records in a circular queue
// and converts execute-lane resolutions into registered branch-result records.
module branch_result_unit #(
    parameter int FETCH_WIDTH     = 2,
    parameter int INT_ISSUE_WIDTH = 2,
    parameter int QUEUE_SIZE      = 16,
    parameter int ADDR_WIDTH      = 32,
    parameter int GH_WIDTH        = 10,
    parameter int PHT_ENTRY_WIDTH = 2,
    localparam int TAG_W  = $clog2(QUEUE_SIZE),
    localparam int CNUM_W = $clog2(INT_ISSUE_WIDTH) + 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [FETCH_WIDTH-1:0]                 alloc_valid,
    input  logic [FETCH_WIDTH*ADDR_WIDTH-1:0]      alloc_addr,
    input  logic [FETCH_WIDTH*GH_WIDTH-1:0]        alloc_gh,
    input  logic [FETCH_WIDTH*PHT_ENTRY_WIDTH-1:0] alloc_pht,
    input  logic [FETCH_WIDTH-1:0]                 alloc_taken,
    input  logic [FETCH_WIDTH*ADDR_WIDTH-1:0]      alloc_target,
    output logic                                   alloc_ready,
    output logic [FETCH_WIDTH*TAG_W-1:0]           alloc_tag,
    input  logic [INT_ISSUE_WIDTH-1:0]             res_valid,
    input  logic [INT_ISSUE_WIDTH*TAG_W-1:0]       res_tag,
    input  logic [INT_ISSUE_WIDTH-1:0]             res_taken,
    input  logic [INT_ISSUE_WIDTH*ADDR_WIDTH-1:0]  res_target,
    input  logic [INT_ISSUE_WIDTH-1:0]             res_is_cond,
    output logic [INT_ISSUE_WIDTH-1:0]             br_valid,
    output logic [INT_ISSUE_WIDTH*ADDR_WIDTH-1:0]  br_addr,
    output logic [INT_ISSUE_WIDTH*GH_WIDTH-1:0]    br_gh,
    output logic [INT_ISSUE_WIDTH*PHT_ENTRY_WIDTH-1:0] br_pht_prev,
    output logic [INT_ISSUE_WIDTH-1:0]             br_exec_taken,
    output logic [INT_ISSUE_WIDTH-1:0]             br_is_cond,
    output logic [INT_ISSUE_WIDTH-1:0]             br_mispred,
    input  logic [CNUM_W-1:0]                      commit_num,
    output logic [TAG_W:0]                         count
);

    localparam int PTR_W = TAG_W + 1;

    logic [ADDR_WIDTH-1:0]      entAddr   [QUEUE_SIZE];
    logic [ADDR_WIDTH-1:0]      entTarget [QUEUE_SIZE];
    logic [GH_WIDTH-1:0]        entGh     [QUEUE_SIZE];
    logic [PHT_ENTRY_WIDTH-1:0] entPht    [QUEUE_SIZE];
    logic                       entTaken  [QUEUE_SIZE];

    logic [PTR_W-1:0] headPtr, tailPtr, headNext, tailNext;
    logic [PTR_W-1:0] allocNum, freeSlots, commitClip, recDist;
    logic             allocFire, recover;
    logic [TAG_W-1:0] recAge;

    logic [TAG_W-1:0]           resTag [INT_ISSUE_WIDTH];
    logic [TAG_W-1:0]           resAge [INT_ISSUE_WIDTH];
    logic [INT_ISSUE_WIDTH-1:0] resHit, resMis;

    logic [INT_ISSUE_WIDTH-1:0]                 brValid_p1, brTaken_p1, brCond_p1, brMis_p1;
    logic [INT_ISSUE_WIDTH*ADDR_WIDTH-1:0]      brAddr_p1;
    logic [INT_ISSUE_WIDTH*GH_WIDTH-1:0]        brGh_p1;
    logic [INT_ISSUE_WIDTH*PHT_ENTRY_WIDTH-1:0] brPht_p1;

    assign count     = tailPtr - headPtr;
    assign freeSlots = PTR_W'(QUEUE_SIZE) - count;

    // Slots are packed in program order: each valid slot takes the next free index.
    always_comb begin
        allocNum  = '0;
        alloc_tag = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            alloc_tag[i*TAG_W +: TAG_W] = tailPtr[TAG_W-1:0] + allocNum[TAG_W-1:0];
            allocNum = allocNum + PTR_W'(alloc_valid[i]);
        end
    end

    assign alloc_ready = (freeSlots >= allocNum);

    for (genvar l = 0; l < INT_ISSUE_WIDTH; l++) begin : g_lane
        logic [ADDR_WIDTH-1:0] tgt;
        logic                  condMis, jumpMis;

        assign resTag[l] = res_tag[l*TAG_W +: TAG_W];
        assign tgt       = res_target[l*ADDR_WIDTH +: ADDR_WIDTH];
        assign resAge[l] = resTag[l] - headPtr[TAG_W-1:0];
        assign resHit[l] = res_valid[l] && ({1'b0, resAge[l]} < count);
        assign condMis   = (res_taken[l] != entTaken[resTag[l]]) ||
                           (res_taken[l] && (tgt != entTarget[resTag[l]]));
        assign jumpMis   = !entTaken[resTag[l]] || (tgt != entTarget[resTag[l]]);
        assign resMis[l] = resHit[l] && (res_is_cond[l] ? condMis : jumpMis);
    end

    // Oldest mispredicting lane wins; age is distance from head.
    always_comb begin
        recover = 1'b0;
        recAge  = '0;
        for (int l = 0; l < INT_ISSUE_WIDTH; l++) begin
            if (resMis[l] && (!recover || (resAge[l] < recAge))) begin
                recover = 1'b1;
                recAge  = resAge[l];
            end
        end
    end

    always_comb begin
        commitClip = (PTR_W'(commit_num) > count) ? count : PTR_W'(commit_num);
        headNext   = headPtr + commitClip;
        recDist    = {1'b0, recAge} + PTR_W'(1);
        allocFire  = alloc_ready && (allocNum != '0) && !recover;
        if (recover) begin
            // A commit past the squash point leaves the queue empty at the new head.
            tailNext = (recDist < commitClip) ? headNext : (headPtr + recDist);
        end else if (allocFire) begin
            tailNext = tailPtr + allocNum;
        end else begin
            tailNext = tailPtr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            headPtr <= '0;
            tailPtr <= '0;
        end else begin
            headPtr <= headNext;
            tailPtr <= tailNext;
        end
    end

    always_ff @(posedge clk) begin
        if (allocFire) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (alloc_valid[i]) begin
                    entAddr[alloc_tag[i*TAG_W +: TAG_W]]   <= alloc_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    entTarget[alloc_tag[i*TAG_W +: TAG_W]] <= alloc_target[i*ADDR_WIDTH +: ADDR_WIDTH];
                    entGh[alloc_tag[i*TAG_W +: TAG_W]]     <= alloc_gh[i*GH_WIDTH +: GH_WIDTH];
                    entPht[alloc_tag[i*TAG_W +: TAG_W]]    <= alloc_pht[i*PHT_ENTRY_WIDTH +: PHT_ENTRY_WIDTH];
                    entTaken[alloc_tag[i*TAG_W +: TAG_W]]  <= alloc_taken[i];
                end
            end
        end
    end

    // ---- resolve -> branch-result record (p1) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brValid_p1 <= '0;
            brTaken_p1 <= '0;
            brCond_p1  <= '0;
            brMis_p1   <= '0;
            brAddr_p1  <= '0;
            brGh_p1    <= '0;
            brPht_p1   <= '0;
        end else begin
            for (int l = 0; l < INT_ISSUE_WIDTH; l++) begin
                brValid_p1[l] <= resHit[l];
                if (resHit[l]) begin
                    brAddr_p1[l*ADDR_WIDTH +: ADDR_WIDTH]          <= entAddr[resTag[l]];
                    brGh_p1[l*GH_WIDTH +: GH_WIDTH]                <= entGh[resTag[l]];
                    brPht_p1[l*PHT_ENTRY_WIDTH +: PHT_ENTRY_WIDTH] <= entPht[resTag[l]];
                    brTaken_p1[l] <= res_taken[l];
                    brCond_p1[l]  <= res_is_cond[l];
                    brMis_p1[l]   <= resMis[l];
                end
            end
        end
    end

    assign br_valid      = brValid_p1;
    assign br_addr       = brAddr_p1;
    assign br_gh         = brGh_p1;
    assign br_pht_prev   = brPht_p1;
    assign br_exec_taken = brTaken_p1;
    assign br_is_cond    = brCond_p1;
    assign br_mispred    = brMis_p1;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (PTR_W'(commit_num) <= count)
                else $error("commit_num %0d exceeds count %0d", commit_num, count);
            for (int l = 0; l < INT_ISSUE_WIDTH; l++) begin
                assert (!res_valid[l] || resHit[l])
                    else $error("lane %0d resolves tag %0d outside the live window", l, resTag[l]);
            end
        end
    end

endmodule
